// File: rtl/ddr_stress_pattern_gen.sv
// ddr_stress_pattern_gen
//   Generates framed write bursts (preamble / data / postamble / gap) for DDR pin stress tests.
//   Drives the ODDR data/strobe/mask inputs, tri-state controls and a write command with a
//   stepping address. Four data patterns are available: counter, walking-one, PRBS7 and
//   checkerboard.
//
// Optional feature: define PATTERN_CHECK_EN to build the loopback checker. It compares
// DQ_Q0/DQ_Q1 against the driven burst data delayed by CHK_LAT cycles and counts mismatching
// cycles in err_cnt. Without the macro err_cnt is tied to 0 and dq_q0/dq_q1 are ignored.
//
// Ports
//   pll_clk_out         fast clock (PLL CLKOP)
//   rst                 asynchronous active-high reset
//   locked              PLL lock; low forces idle
//   en                  run enable
//   mode                0 counter, 1 walking-one, 2 PRBS7, 3 checkerboard
//   dq_d0/dq_d1         rising/falling-edge DQ data, 8 bits per lane
//   dq_t                DQ/DM tri-state (1 = hi-Z)
//   dqs_d0/dqs_d1       strobe data per lane
//   dqs_t               DQS tri-state (1 = hi-Z)
//   dm_d0/dm_d1         data mask, always 0
//   cs_n..we_n          registered command
//   a, ba               burst address and bank address
//   busy                high outside idle
//   burst_cnt           completed bursts, saturating
//   dq_q0/dq_q1         loopback capture (checker only)
//   err_cnt             mismatching cycles, saturating (checker only)
module ddr_stress_pattern_gen #(
  parameter int unsigned LANES     = 2,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned BA_W      = 3,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned GAP_LEN   = 2,
  parameter int unsigned CHK_LAT   = 3
) (
  input  logic                 pll_clk_out,
  input  logic                 rst,
  input  logic                 locked,
  input  logic                 en,
  input  logic [1:0]           mode,
  output logic [8*LANES-1:0]   dq_d0,
  output logic [8*LANES-1:0]   dq_d1,
  output logic                 dq_t,
  output logic [LANES-1:0]     dqs_d0,
  output logic [LANES-1:0]     dqs_d1,
  output logic                 dqs_t,
  output logic [LANES-1:0]     dm_d0,
  output logic [LANES-1:0]     dm_d1,
  output logic                 cs_n,
  output logic                 ras_n,
  output logic                 cas_n,
  output logic                 we_n,
  output logic [ADDR_W-1:0]    a,
  output logic [BA_W-1:0]      ba,
  output logic                 busy,
  output logic [15:0]          burst_cnt,
  input  logic [8*LANES-1:0]   dq_q0,
  input  logic [8*LANES-1:0]   dq_q1,
  output logic [15:0]          err_cnt
);

  localparam int unsigned     DW        = 8 * LANES;
  localparam logic [15:0]     BurstLast = 16'(BURST_LEN - 1);
  localparam logic [15:0]     GapLast   = 16'(GAP_LEN - 1);
  localparam logic [ADDR_W:0] AddrStep  = (ADDR_W + 1)'(2 * BURST_LEN);

  typedef enum logic [2:0] {StIdle, StPre, StBurst, StPost, StGap} state_e;

  state_e          state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [1:0]      mode_q;
  logic [7:0]      ctr_q, walk_q;
  logic [6:0]      prbs_q   [LANES];
  logic [6:0]      prbs_nxt [LANES];
  logic [15:0]     prbs_bits[LANES];
  logic [DW-1:0]   pat_w0, pat_w1;
  logic            start, mode_chg, gen_step, burst_end;
  logic [ADDR_W:0] addr_sum;
  logic [DW-1:0]   dq_d0_d, dq_d1_d;
  logic            dq_t_d, dqs_t_d, dqs_on_d;
  logic [3:0]      cmd_d, cmd_q;

  // Advance a PRBS7 (x^7 + x^6 + 1) by 16 bits; first generated bit lands in bit 15.
  function automatic logic [22:0] prbs_adv(input logic [6:0] seed);
    logic [6:0]  s;
    logic [15:0] bits;
    logic        nb;
    s    = seed;
    bits = '0;
    for (int i = 0; i < 16; i++) begin
      nb          = s[6] ^ s[5];
      bits[15-i]  = nb;
      s           = {s[5:0], nb};
    end
    return {s, bits};
  endfunction

  // Frame sequencer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!locked) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle:  if (en) state_d = StPre;
        StPre: begin
          state_d = StBurst;
          cnt_d   = '0;
        end
        StBurst: begin
          if (cnt_q == BurstLast) begin
            state_d = StPost;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        StPost: begin
          state_d = StGap;
          cnt_d   = '0;
        end
        StGap: begin
          if (cnt_q == GapLast) begin
            state_d = en ? StPre : StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign start     = (state_q == StIdle) && (state_d == StPre);
  assign mode_chg  = start && (mode != mode_q);
  assign gen_step  = (state_d == StBurst);
  assign burst_end = (state_q == StBurst) && (state_d == StPost);
  assign addr_sum  = {1'b0, a} + AddrStep;

  always_ff @(posedge pll_clk_out or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Pattern words for the current generator state
  always_comb begin
    pat_w0 = '0;
    pat_w1 = '0;
    for (int l = 0; l < LANES; l++) begin
      {prbs_nxt[l], prbs_bits[l]} = prbs_adv(prbs_q[l]);
      unique case (mode_q)
        2'd0: begin
          pat_w0[8*l +: 8] = ctr_q;
          pat_w1[8*l +: 8] = ctr_q + 8'd1;
        end
        2'd1: begin
          pat_w0[8*l +: 8] = walk_q;
          pat_w1[8*l +: 8] = {walk_q[6:0], walk_q[7]};
        end
        2'd2: begin
          pat_w0[8*l +: 8] = prbs_bits[l][15:8];
          pat_w1[8*l +: 8] = prbs_bits[l][7:0];
        end
        default: begin
          pat_w0[8*l +: 8] = 8'h55;
          pat_w1[8*l +: 8] = 8'hAA;
        end
      endcase
    end
  end

  // Mode is latched only on a fresh start; a different mode reloads every seed.
  always_ff @(posedge pll_clk_out or posedge rst) begin
    if (rst) begin
      mode_q <= 2'd0;
      ctr_q  <= 8'h00;
      walk_q <= 8'h01;
      for (int l = 0; l < LANES; l++) prbs_q[l] <= 7'h7F ^ 7'(l);
    end else if (mode_chg) begin
      mode_q <= mode;
      ctr_q  <= 8'h00;
      walk_q <= 8'h01;
      for (int l = 0; l < LANES; l++) prbs_q[l] <= 7'h7F ^ 7'(l);
    end else if (gen_step) begin
      unique case (mode_q)
        2'd0:    ctr_q  <= ctr_q + 8'd2;
        2'd1:    walk_q <= {walk_q[5:0], walk_q[7:6]};
        2'd2:    for (int l = 0; l < LANES; l++) prbs_q[l] <= prbs_nxt[l];
        default: ;
      endcase
    end
  end

  // Output values for the state being entered, registered on the same edge
  always_comb begin
    dq_d0_d  = '0;
    dq_d1_d  = '0;
    dq_t_d   = 1'b1;
    dqs_t_d  = 1'b1;
    dqs_on_d = 1'b0;
    cmd_d    = 4'b1111;
    unique case (state_d)
      StPre: begin
        dqs_t_d = 1'b0;
        cmd_d   = 4'b0100;
      end
      StBurst: begin
        dq_t_d   = 1'b0;
        dqs_t_d  = 1'b0;
        dqs_on_d = 1'b1;
        dq_d0_d  = pat_w0;
        dq_d1_d  = pat_w1;
      end
      StPost:  dqs_t_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge pll_clk_out or posedge rst) begin
    if (rst) begin
      dq_d0  <= '0;
      dq_d1  <= '0;
      dq_t   <= 1'b1;
      dqs_t  <= 1'b1;
      dqs_d0 <= '0;
      cmd_q  <= 4'b1111;
    end else begin
      dq_d0  <= dq_d0_d;
      dq_d1  <= dq_d1_d;
      dq_t   <= dq_t_d;
      dqs_t  <= dqs_t_d;
      dqs_d0 <= {LANES{dqs_on_d}};
      cmd_q  <= cmd_d;
    end
  end

  assign {cs_n, ras_n, cas_n, we_n} = cmd_q;
  assign dqs_d1 = '0;
  assign dm_d0  = '0;
  assign dm_d1  = '0;
  assign busy   = (state_q != StIdle);

  // Address / bank stepping and burst counter; a lock loss never reaches burst_end.
  always_ff @(posedge pll_clk_out or posedge rst) begin
    if (rst) begin
      a         <= '0;
      ba        <= '0;
      burst_cnt <= '0;
    end else if (burst_end) begin
      a <= addr_sum[ADDR_W-1:0];
      if (addr_sum[ADDR_W]) ba <= ba + BA_W'(1);
      if (burst_cnt != 16'hFFFF) burst_cnt <= burst_cnt + 16'd1;
    end
  end

`ifdef PATTERN_CHECK_EN
  // Each entry: {burst beat valid, w1, w0} as driven; the oldest entry lines up with dq_q.
  logic [2*DW:0] chk_q [CHK_LAT];

  always_ff @(posedge pll_clk_out or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHK_LAT; i++) chk_q[i] <= '0;
      err_cnt <= '0;
    end else begin
      chk_q[0] <= {~dq_t, dq_d1, dq_d0};
      for (int i = 1; i < CHK_LAT; i++) chk_q[i] <= chk_q[i-1];
      if (chk_q[CHK_LAT-1][2*DW] && ({dq_q1, dq_q0} != chk_q[CHK_LAT-1][2*DW-1:0]) &&
          (err_cnt != 16'hFFFF)) begin
        err_cnt <= err_cnt + 16'd1;
      end
    end
  end
`else
  logic unused_chk;
  assign unused_chk = ^{dq_q0, dq_q1, 32'(CHK_LAT)};
  assign err_cnt    = '0;
`endif

endmodule
